fft8_frame_ctrl: RTL
====================

// Module: fft8_frame_ctrl
// PURPOSE
//  Frame sequencer in front of the 8-point FFT pipeline. Collects 8 complex
//  samples from a serial valid/ready stream and presents them to the core as
//  a stable parallel frame. Issues the start pulse, waits for done with a
//  timeout, then drains the 8 results serially with back-pressure.
// PARAMETERS
//  SIZE_DATA       32  width of each real/imag word (IEEE-754 single, opaque here)
//  TIMEOUT_CYCLES  16  max cycles in WAIT before abort; must be >= 2
// PORTS
//  i_clk          in   1            clock, all logic on posedge
//  i_rst_n        in   1            async active-low reset
//  i_clear        in   1            sync abort: return to IDLE, drop frame
//  s_valid        in   1            input sample valid
//  s_ready        out  1            input sample ready
//  s_data_re      in   SIZE_DATA    input sample real
//  s_data_im      in   SIZE_DATA    input sample imag
//  m_valid        out  1            output bin valid
//  m_ready        in   1            output bin ready
//  m_data_re      out  SIZE_DATA    output bin real
//  m_data_im      out  SIZE_DATA    output bin imag
//  m_index        out  3            bin number of current output word
//  m_last         out  1            high with the 8th output word of a frame
//  o_fft_start    out  1            start to core, 1-cycle pulse
//  o_fft_x_re     out  8*SIZE_DATA  frame to core real, x0 in [SIZE_DATA-1:0]
//  o_fft_x_im     out  8*SIZE_DATA  frame to core imag, same packing
//  i_fft_done     in   1            done from core, 1-cycle pulse
//  i_fft_X_re     in   8*SIZE_DATA  core results real, X0 in LSBs
//  i_fft_X_im     in   8*SIZE_DATA  core results imag, same packing
//  o_busy         out  1            high in every state except IDLE/LOAD with count 0
//  o_err_timeout  out  1            sticky: WAIT timed out; cleared by i_clear
//  o_frame_cnt    out  16           frames fully drained, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state LOAD, sample count 0, all buffers 0; s_ready=1, m_valid=0,
//   m_last=0, m_index=0, o_fft_start=0, o_busy=0, o_err_timeout=0, o_frame_cnt=0.
//  States: LOAD -> START -> WAIT -> UNLOAD -> LOAD.
//  LOAD: s_ready=1; on s_valid&s_ready store sample at slot cnt, cnt++.
//   Accepting slot 7 -> START next cycle; cnt wraps to 0.
//  START: s_ready=0, o_fft_start=1 for exactly this cycle -> WAIT.
//   o_fft_start is low at least 2 cycles between frames (core edge-detects start).
//  WAIT: o_fft_x_* held stable (buffer not written outside LOAD). Timer counts
//   from 0 each cycle; i_fft_done=1 -> latch all 16 result words into output
//   buffer, -> UNLOAD. Timer reaching TIMEOUT_CYCLES-1 with no done -> set
//   o_err_timeout, drop frame, -> LOAD. i_fft_done outside WAIT ignored.
//  UNLOAD: m_valid=1 from first cycle after done is sampled; word k of output
//   order on m_data_*, m_index=bin. Advance on m_valid&m_ready only; data
//   stable while m_ready=0. m_last=1 on 8th word; its handshake -> LOAD,
//   o_frame_cnt++.
//  Latency: last input accept at cycle N -> o_fft_start at N+1; done sampled
//   at D -> m_valid at D+1; full drain = 8 cycles with m_ready held 1.
//  i_clear: highest priority, any state; next cycle as reset except
//   o_frame_cnt kept. i_rst_n low mid-frame: immediate return to reset values.
//  Simultaneous done and timeout edge in same cycle: done wins.
// CONFIGURATION
//  FFT8_BITREV_OUT_EN defined: UNLOAD order 0,4,2,6,1,5,3,7 (bit-reversed
//   index); m_index reports the true bin.
//  Not defined: natural order 0..7, m_index = 0..7.
// TESTING
//  Impulse: x0=1.0(0x3F800000), rest 0, m_ready=1 -> 8 words re=0x3F800000,
//   im=0, m_index 0..7, m_last on 8th, o_frame_cnt=1.
//  Gapped input: s_valid toggled 1/0 -> exactly 8 accepts, one o_fft_start,
//   o_fft_x_* unchanged from START until done.
//  Back-pressure: m_ready low 3 cycles on word 2 -> word 2 held stable, no
//   word skipped/duplicated, s_ready stays 0 until m_last handshake.
//  Timeout: never pulse done -> after TIMEOUT_CYCLES o_err_timeout=1, state
//   LOAD, m_valid never 1; i_clear then clears error.
//  Abort: i_clear after 5 samples and again mid-UNLOAD -> count restarts at 0,
//   m_valid drops next cycle, o_frame_cnt unchanged.
//  With FFT8_BITREV_OUT_EN: ramp frame -> m_index sequence 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point FFT core: serial load, start/done handshake with timeout, serial drain.
// Define FFT8_BITREV_OUT_EN to drain bins in bit-reversed order (m_index still reports the true bin).
module fft8_frame_ctrl #(
  parameter int unsigned SIZE_DATA      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [SIZE_DATA-1:0]   s_data_re,
  input  logic [SIZE_DATA-1:0]   s_data_im,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [SIZE_DATA-1:0]   m_data_re,
  output logic [SIZE_DATA-1:0]   m_data_im,
  output logic [2:0]             m_index,
  output logic                   m_last,
  output logic                   o_fft_start,
  output logic [8*SIZE_DATA-1:0] o_fft_x_re,
  output logic [8*SIZE_DATA-1:0] o_fft_x_im,
  input  logic                   i_fft_done,
  input  logic [8*SIZE_DATA-1:0] i_fft_X_re,
  input  logic [8*SIZE_DATA-1:0] i_fft_X_im,
  output logic                   o_busy,
  output logic                   o_err_timeout,
  output logic [15:0]            o_frame_cnt
);

  localparam int unsigned NUM_PTS = 8;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned TMR_W   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_UNLOAD
  } state_e;

  typedef logic [NUM_PTS-1:0][SIZE_DATA-1:0] frame_t;

  // Drain order: position k in the output stream maps to this bin.
  function automatic logic [IDX_W-1:0] out_bin(input logic [IDX_W-1:0] k);
`ifdef FFT8_BITREV_OUT_EN
    return {k[0], k[1], k[2]};
`else
    return k;
`endif
  endfunction

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]     optr_q, optr_d;
  frame_t               in_re_q, in_re_d;
  frame_t               in_im_q, in_im_d;
  frame_t               out_re_q, out_re_d;
  frame_t               out_im_q, out_im_d;
  logic [SIZE_DATA-1:0] m_re_q, m_re_d;
  logic [SIZE_DATA-1:0] m_im_q, m_im_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                 s_ready_q, s_ready_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_last_q, m_last_d;
  logic [IDX_W-1:0]     m_index_q, m_index_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      timer_q     <= '0;
      optr_q      <= '0;
      in_re_q     <= '0;
      in_im_q     <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      m_re_q      <= '0;
      m_im_q      <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_index_q   <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      optr_q      <= optr_d;
      in_re_q     <= in_re_d;
      in_im_q     <= in_im_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      m_re_q      <= m_re_d;
      m_im_q      <= m_im_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      s_ready_q   <= s_ready_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_index_q   <= m_index_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; output flags are decoded from the next state so they align with it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    optr_d      = optr_q;
    in_re_d     = in_re_q;
    in_im_d     = in_im_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    m_re_d      = m_re_q;
    m_im_d      = m_im_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    s_ready_d   = 1'b0;
    m_valid_d   = 1'b0;
    m_last_d    = 1'b0;
    m_index_d   = '0;
    start_d     = 1'b0;
    busy_d      = 1'b0;

    if (i_clear) begin
      state_d  = ST_LOAD;
      cnt_d    = '0;
      timer_d  = '0;
      optr_d   = '0;
      in_re_d  = '0;
      in_im_d  = '0;
      out_re_d = '0;
      out_im_d = '0;
      m_re_d   = '0;
      m_im_d   = '0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          if (s_valid) begin
            in_re_d[cnt_q] = s_data_re;
            in_im_d[cnt_q] = s_data_im;
            if (cnt_q == IDX_W'(NUM_PTS - 1)) begin
              cnt_d   = '0;
              state_d = ST_START;
            end else begin
              cnt_d = IDX_W'(cnt_q + IDX_W'(1));
            end
          end
        end
        ST_START: begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          // Done takes precedence over a timeout expiring in the same cycle.
          if (i_fft_done) begin
            out_re_d = frame_t'(i_fft_X_re);
            out_im_d = frame_t'(i_fft_X_im);
            optr_d   = '0;
            m_re_d   = out_re_d[out_bin('0)];
            m_im_d   = out_im_d[out_bin('0)];
            state_d  = ST_UNLOAD;
          end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            timer_d = TMR_W'(timer_q + TMR_W'(1));
          end
        end
        ST_UNLOAD: begin
          if (m_ready) begin
            if (optr_q == IDX_W'(NUM_PTS - 1)) begin
              optr_d      = '0;
              frame_cnt_d = CNT_W'(frame_cnt_q + CNT_W'(1));
              state_d     = ST_LOAD;
            end else begin
              optr_d = IDX_W'(optr_q + IDX_W'(1));
              m_re_d = out_re_q[out_bin(optr_d)];
              m_im_d = out_im_q[out_bin(optr_d)];
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end

    s_ready_d = (state_d == ST_LOAD);
    start_d   = (state_d == ST_START);
    m_valid_d = (state_d == ST_UNLOAD);
    m_last_d  = (state_d == ST_UNLOAD) && (optr_d == IDX_W'(NUM_PTS - 1));
    m_index_d = (state_d == ST_UNLOAD) ? out_bin(optr_d) : '0;
    busy_d    = !((state_d == ST_LOAD) && (cnt_d == '0));
  end

  assign s_ready       = s_ready_q;
  assign m_valid       = m_valid_q;
  assign m_data_re     = m_re_q;
  assign m_data_im     = m_im_q;
  assign m_index       = m_index_q;
  assign m_last        = m_last_q;
  assign o_fft_start   = start_q;
  assign o_fft_x_re    = in_re_q;
  assign o_fft_x_im    = in_im_q;
  assign o_busy        = busy_q;
  assign o_err_timeout = err_q;
  assign o_frame_cnt   = frame_cnt_q;

endmodule
